// File: rtl/dmem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arb_pkg
//  Description : Shared types and constants for the DataMemory port arbiter.
//                It holds the FSM state encoding, the requester identity
//                encoding, the bus widths, the memory geometry and a helper
//                that checks whether an address is in range.
//  Revision    : 1.0 - initial release
// ============================================================================
package dmem_arb_pkg;

    localparam int ADDR_W    = 24;
    localparam int DATA_W    = 24;
    localparam int MEM_BYTES = 128;
    localparam int WORD_B    = 3;

    // Highest byte address at which a whole word still fits in memory.
    localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(MEM_BYTES - WORD_B);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DBG = 1'b1
    } owner_e;

    // Unsigned range check. Any address with upper bits set is also rejected.
    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
        return (addr <= MAX_ADDR);
    endfunction

endpackage : dmem_arb_pkg
`default_nettype wire

// File: rtl/dmem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_req_if / dmem_mem_if
//  Description : Bus bundles used by the DataMemory port arbiter.
//                dmem_req_if : req/ack requester channel (CPU LSU or debug).
//                  master = requester, slave = arbiter
//                  req, we, addr, wdata : requester -> arbiter
//                  ack, rdata, err      : arbiter   -> requester
//                dmem_mem_if : DataMemory port.
//                  master = arbiter, slave = memory
//                  address, write_data, mem_write, mem_read : arbiter -> memory
//                  read_data                                : memory  -> arbiter
//  Revision    : 1.0 - initial release
// ============================================================================
interface dmem_req_if;
    import dmem_arb_pkg::*;

    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;
    logic              err;

    modport master (
        output req, we, addr, wdata,
        input  ack, rdata, err
    );

    modport slave (
        input  req, we, addr, wdata,
        output ack, rdata, err
    );
endinterface : dmem_req_if

interface dmem_mem_if;
    import dmem_arb_pkg::*;

    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] write_data;
    logic              mem_write;
    logic              mem_read;
    logic [DATA_W-1:0] read_data;

    modport master (
        output address, write_data, mem_write, mem_read,
        input  read_data
    );

    modport slave (
        input  address, write_data, mem_write, mem_read,
        output read_data
    );
endinterface : dmem_mem_if
`default_nettype wire

// File: rtl/dmem_port_arbiter_rr.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter2
//  Description : Two-way round-robin picker. This block is purely
//                combinational. A single requester is granted directly. When
//                both request, the side that did not win last time gets the
//                grant.
//  Ports       : req_i[1:0]   request vector, bit 0 = CPU, bit 1 = debug
//                last_grant_i side that won the previous arbitration
//                enable_i     arbitration allowed this cycle
//                grant_o[1:0] one-hot grant, zero when disabled or idle
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  owner_e     last_grant_i,
    input  logic       enable_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = 2'b00;
        if (enable_i) begin
            case (req_i)
                2'b01:   grant_o = 2'b01;
                2'b10:   grant_o = 2'b10;
                2'b11:   grant_o = (last_grant_i == OWN_DBG) ? 2'b01 : 2'b10;
                default: grant_o = 2'b00;
            endcase
        end
    end

endmodule : rr_arbiter2
`default_nettype wire

// File: rtl/dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_port_arbiter
//  Description : Shares the single big-endian, byte-addressed DataMemory port
//                between the CPU load/store unit and the debug/DMA port.
//                Arbitration is round-robin, and each transaction moves one
//                24-bit word. An out-of-range address is answered with an
//                error and never reaches memory.
//                Normal flow : IDLE -> ACCESS -> RESP -> IDLE
//                Error flow  : IDLE -> RESP -> IDLE
//  Ports       : clk_i   system clock, rising edge
//                rst_ni  asynchronous active-low reset
//                cpu_if  CPU requester channel (slave side)
//                dbg_if  debug requester channel (slave side)
//                mem_if  DataMemory port (master side), all outputs registered
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_port_arbiter
    import dmem_arb_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    dmem_req_if.slave  cpu_if,
    dmem_req_if.slave  dbg_if,
    dmem_mem_if.master mem_if
);

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_e            state_q;
    owner_e            owner_q;
    owner_e            last_grant_q;

    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              mem_write_q;
    logic              mem_read_q;

    logic              cpu_ack_q;
    logic              cpu_err_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic              dbg_ack_q;
    logic              dbg_err_q;
    logic [DATA_W-1:0] dbg_rdata_q;

    // ------------------------------------------------------------------
    // Arbitration and request selection
    // ------------------------------------------------------------------
    logic [1:0]        req_vec_d;
    logic [1:0]        grant_d;
    owner_e            sel_owner_d;
    logic              sel_we_d;
    logic [ADDR_W-1:0] sel_addr_d;
    logic [DATA_W-1:0] sel_wdata_d;
    logic              addr_err_d;

    assign req_vec_d = {dbg_if.req, cpu_if.req};

    rr_arbiter2 u_rr_arbiter2 (
        .req_i        (req_vec_d),
        .last_grant_i (last_grant_q),
        .enable_i     (state_q == IDLE),
        .grant_o      (grant_d)
    );

    always_comb begin
        sel_owner_d = grant_d[1] ? OWN_DBG : OWN_CPU;
        sel_we_d    = grant_d[1] ? dbg_if.we    : cpu_if.we;
        sel_addr_d  = grant_d[1] ? dbg_if.addr  : cpu_if.addr;
        sel_wdata_d = grant_d[1] ? dbg_if.wdata : cpu_if.wdata;
        addr_err_d  = !addr_in_range(sel_addr_d);
    end

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    //
    // Ack and Err are raised on the edge that enters RESP, so that they are
    // visible for the whole RESP cycle. This gives an Ack two cycles after
    // the request is sampled, or one cycle after it on an error. The async
    // reset clears the memory strobes at once, which aborts a store in flight
    // before it can commit.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            owner_q      <= OWN_CPU;
            last_grant_q <= OWN_DBG;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            cpu_ack_q    <= 1'b0;
            cpu_err_q    <= 1'b0;
            cpu_rdata_q  <= '0;
            dbg_ack_q    <= 1'b0;
            dbg_err_q    <= 1'b0;
            dbg_rdata_q  <= '0;
        end else begin
            // Ack/Err are single-cycle pulses.
            cpu_ack_q <= 1'b0;
            cpu_err_q <= 1'b0;
            dbg_ack_q <= 1'b0;
            dbg_err_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (grant_d != 2'b00) begin
                        owner_q      <= sel_owner_d;
                        last_grant_q <= sel_owner_d;
                        if (addr_err_d) begin
                            // Rejected: memory strobes stay low.
                            if (sel_owner_d == OWN_CPU) begin
                                cpu_ack_q <= 1'b1;
                                cpu_err_q <= 1'b1;
                            end else begin
                                dbg_ack_q <= 1'b1;
                                dbg_err_q <= 1'b1;
                            end
                            state_q <= RESP;
                        end else begin
                            mem_addr_q  <= sel_addr_d;
                            mem_wdata_q <= sel_wdata_d;
                            mem_write_q <= sel_we_d;
                            mem_read_q  <= !sel_we_d;
                            state_q     <= ACCESS;
                        end
                    end
                end

                ACCESS: begin
                    // Memory read is combinational, so the word is valid now.
                    if (owner_q == OWN_CPU) begin
                        if (mem_read_q) begin
                            cpu_rdata_q <= mem_if.read_data;
                        end
                        cpu_ack_q <= 1'b1;
                    end else begin
                        if (mem_read_q) begin
                            dbg_rdata_q <= mem_if.read_data;
                        end
                        dbg_ack_q <= 1'b1;
                    end
                    mem_addr_q  <= '0;
                    mem_wdata_q <= '0;
                    mem_write_q <= 1'b0;
                    mem_read_q  <= 1'b0;
                    state_q     <= RESP;
                end

                RESP: begin
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output drive
    // ------------------------------------------------------------------
    assign mem_if.address    = mem_addr_q;
    assign mem_if.write_data = mem_wdata_q;
    assign mem_if.mem_write  = mem_write_q;
    assign mem_if.mem_read   = mem_read_q;

    assign cpu_if.ack   = cpu_ack_q;
    assign cpu_if.err   = cpu_err_q;
    assign cpu_if.rdata = cpu_rdata_q;
    assign dbg_if.ack   = dbg_ack_q;
    assign dbg_if.err   = dbg_err_q;
    assign dbg_if.rdata = dbg_rdata_q;

endmodule : dmem_port_arbiter
`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_port_arbiter
//  Description : Directed self-checking bench for dmem_port_arbiter. It
//                contains a 128-byte big-endian memory model with a
//                combinational read.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_port_arbiter;
    import dmem_arb_pkg::*;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    logic [7:0]        tbmem [0:MEM_BYTES-1];
    logic [DATA_W-1:0] rd_word;

    dmem_req_if cpu_if ();
    dmem_req_if dbg_if ();
    dmem_mem_if mem_if ();

    dmem_port_arbiter dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .cpu_if (cpu_if),
        .dbg_if (dbg_if),
        .mem_if (mem_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: combinational read, write on the rising edge.
    always_comb begin
        int ai;
        rd_word = '0;
        ai      = int'(mem_if.address[6:0]);
        if (mem_if.address <= 24'd125) begin
            rd_word = {tbmem[ai], tbmem[ai+1], tbmem[ai+2]};
        end
    end
    assign mem_if.read_data = rd_word;

    always @(posedge clk) begin
        int wi;
        wi = int'(mem_if.address[6:0]);
        if (mem_if.mem_write && mem_if.address <= 24'd125) begin
            tbmem[wi]   <= mem_if.write_data[23:16];
            tbmem[wi+1] <= mem_if.write_data[15:8];
            tbmem[wi+2] <= mem_if.write_data[7:0];
        end
    end

    // Continuous invariants: no read/write overlap, never two Acks at once.
    always @(negedge clk) begin
        if (rst_n) begin
            n_checks++;
            if ((mem_if.mem_write && mem_if.mem_read) || (cpu_if.ack && dbg_if.ack)) begin
                n_fail++;
                $display("FAIL exclusive: wr=%0b rd=%0b cpu_ack=%0b dbg_ack=%0b, required no overlap",
                         mem_if.mem_write, mem_if.mem_read, cpu_if.ack, dbg_if.ack);
            end
        end
    end

    // Drives one request on one side and waits for its Ack, up to 20 cycles.
    // lat is the count of negedges from the request cycle (3 means Ack at
    // N+2) and is -1 on timeout.
    task automatic run_req(input bit dbg, input bit we, input logic [23:0] addr,
                           input logic [23:0] wdata, output int lat, output bit err,
                           output logic [23:0] rd, output int nwr, output int nrd,
                           output bit other_ack, output logic [23:0] wr_addr,
                           output logic [23:0] wr_data);
        lat = -1; err = 1'b0; rd = '0; nwr = 0; nrd = 0; other_ack = 1'b0;
        wr_addr = '0; wr_data = '0;
        @(posedge clk); #1;
        if (dbg) begin
            dbg_if.we = we; dbg_if.addr = addr; dbg_if.wdata = wdata; dbg_if.req = 1'b1;
        end else begin
            cpu_if.we = we; cpu_if.addr = addr; cpu_if.wdata = wdata; cpu_if.req = 1'b1;
        end
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (mem_if.mem_write) begin
                nwr++;
                wr_addr = mem_if.address;
                wr_data = mem_if.write_data;
            end
            if (mem_if.mem_read) nrd++;
            if (dbg ? cpu_if.ack : dbg_if.ack) other_ack = 1'b1;
            if (dbg ? dbg_if.ack : cpu_if.ack) begin
                lat = k;
                err = dbg ? dbg_if.err : cpu_if.err;
                rd  = dbg ? dbg_if.rdata : cpu_if.rdata;
                break;
            end
        end
        @(posedge clk); #1;
        if (dbg) dbg_if.req = 1'b0; else cpu_if.req = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_checks++;
        if ({mem_if.mem_write, mem_if.mem_read, mem_if.address, mem_if.write_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_mem: got wr=%0b rd=%0b addr=%h wd=%h, required all 0",
                     mem_if.mem_write, mem_if.mem_read, mem_if.address, mem_if.write_data);
        end
        n_checks++;
        if ({cpu_if.ack, cpu_if.err, cpu_if.rdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_cpu: got ack=%0b err=%0b rdata=%h, required 0",
                     cpu_if.ack, cpu_if.err, cpu_if.rdata);
        end
        n_checks++;
        if ({dbg_if.ack, dbg_if.err, dbg_if.rdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_dbg: got ack=%0b err=%0b rdata=%h, required 0",
                     dbg_if.ack, dbg_if.err, dbg_if.rdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    // Both requesters rise together right after reset: CPU first, debug later.
    task automatic test_simultaneous();
        int cpu_k, dbg_k, nrd;
        cpu_k = -1; dbg_k = -1; nrd = 0;
        @(posedge clk); #1;
        cpu_if.we = 1'b0; cpu_if.addr = 24'h000010; cpu_if.wdata = '0; cpu_if.req = 1'b1;
        dbg_if.we = 1'b0; dbg_if.addr = 24'h000020; dbg_if.wdata = '0; dbg_if.req = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (mem_if.mem_read) nrd++;
            if (cpu_if.ack && cpu_k < 0) begin
                cpu_k = k;
                n_checks++;
                if (cpu_if.rdata !== 24'h101112) begin
                    n_fail++;
                    $display("FAIL sim_cpu_rdata: got %h, required 101112", cpu_if.rdata);
                end
            end
            if (dbg_if.ack && dbg_k < 0) begin
                dbg_k = k;
                n_checks++;
                if (dbg_if.rdata !== 24'h202122) begin
                    n_fail++;
                    $display("FAIL sim_dbg_rdata: got %h, required 202122", dbg_if.rdata);
                end
            end
            @(posedge clk); #1;
            if (cpu_k > 0) cpu_if.req = 1'b0;
            if (dbg_k > 0) dbg_if.req = 1'b0;
            if (cpu_k > 0 && dbg_k > 0) break;
        end
        cpu_if.req = 1'b0; dbg_if.req = 1'b0;
        n_checks++;
        if (cpu_k != 3) begin
            n_fail++;
            $display("FAIL sim_cpu_latency: got %0d, required 3", cpu_k);
        end
        n_checks++;
        if (dbg_k != 6) begin
            n_fail++;
            $display("FAIL sim_dbg_latency: got %0d, required 6", dbg_k);
        end
        n_checks++;
        if (nrd != 2) begin
            n_fail++;
            $display("FAIL sim_read_cycles: got %0d, required 2", nrd);
        end
    endtask

    // Both held high: grants alternate, starting with the CPU.
    task automatic test_back_to_back();
        logic [5:0] seq;
        int n;
        seq = '0; n = 0;
        @(posedge clk); #1;
        cpu_if.req = 1'b1; dbg_if.req = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (cpu_if.ack && n < 6) begin
                seq[n] = 1'b0; n++;
                n_checks++;
                if (cpu_if.rdata !== 24'h101112) begin
                    n_fail++;
                    $display("FAIL b2b_cpu_rdata: got %h, required 101112", cpu_if.rdata);
                end
            end else if (dbg_if.ack && n < 6) begin
                seq[n] = 1'b1; n++;
                n_checks++;
                if (dbg_if.rdata !== 24'h202122) begin
                    n_fail++;
                    $display("FAIL b2b_dbg_rdata: got %h, required 202122", dbg_if.rdata);
                end
            end
            if (n == 6) break;
        end
        @(posedge clk); #1;
        cpu_if.req = 1'b0; dbg_if.req = 1'b0;
        n_checks++;
        if (n != 6 || seq !== 6'b101010) begin
            n_fail++;
            $display("FAIL b2b_order: got n=%0d seq=%b, required n=6 seq=101010", n, seq);
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic test_store_load();
        int lat, nwr, nrd;
        bit err, oth;
        logic [23:0] rd, wa, wd;
        run_req(1'b0, 1'b1, 24'h000010, 24'hA1B2C3, lat, err, rd, nwr, nrd, oth, wa, wd);
        n_checks++;
        if (lat != 3 || err !== 1'b0 || oth) begin
            n_fail++;
            $display("FAIL store_ack: got lat=%0d err=%0b other=%0b, required lat=3 err=0 other=0",
                     lat, err, oth);
        end
        n_checks++;
        if (nwr != 1 || nrd != 0 || wa !== 24'h000010 || wd !== 24'hA1B2C3) begin
            n_fail++;
            $display("FAIL store_bus: got nwr=%0d nrd=%0d addr=%h data=%h, required 1 0 000010 a1b2c3",
                     nwr, nrd, wa, wd);
        end
        n_checks++;
        if ({tbmem[16], tbmem[17], tbmem[18]} !== 24'hA1B2C3) begin
            n_fail++;
            $display("FAIL store_bytes: got %h, required a1b2c3", {tbmem[16], tbmem[17], tbmem[18]});
        end
        run_req(1'b0, 1'b0, 24'h000010, 24'h000000, lat, err, rd, nwr, nrd, oth, wa, wd);
        n_checks++;
        if (lat != 3 || err !== 1'b0 || rd !== 24'hA1B2C3 || nrd != 1 || nwr != 0) begin
            n_fail++;
            $display("FAIL load_back: got lat=%0d err=%0b rd=%h nrd=%0d nwr=%0d, required 3 0 a1b2c3 1 0",
                     lat, err, rd, nrd, nwr);
        end
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (cpu_if.rdata !== 24'hA1B2C3 || dbg_if.rdata !== 24'h202122) begin
            n_fail++;
            $display("FAIL rdata_hold: got cpu=%h dbg=%h, required a1b2c3 202122",
                     cpu_if.rdata, dbg_if.rdata);
        end
    endtask

    task automatic test_range_error();
        int lat, nwr, nrd;
        bit err, oth;
        logic [23:0] rd, wa, wd;
        run_req(1'b1, 1'b0, 24'h00007E, 24'h000000, lat, err, rd, nwr, nrd, oth, wa, wd);
        n_checks++;
        if (lat != 2 || err !== 1'b1 || oth) begin
            n_fail++;
            $display("FAIL err126_ack: got lat=%0d err=%0b other=%0b, required lat=2 err=1 other=0",
                     lat, err, oth);
        end
        n_checks++;
        if (nwr != 0 || nrd != 0 || rd !== 24'h202122) begin
            n_fail++;
            $display("FAIL err126_bus: got nwr=%0d nrd=%0d rd=%h, required 0 0 202122", nwr, nrd, rd);
        end
        run_req(1'b0, 1'b1, 24'h800000, 24'hFFFFFF, lat, err, rd, nwr, nrd, oth, wa, wd);
        n_checks++;
        if (lat != 2 || err !== 1'b1 || nwr != 0) begin
            n_fail++;
            $display("FAIL err_high_addr: got lat=%0d err=%0b nwr=%0d, required 2 1 0", lat, err, nwr);
        end
    endtask

    task automatic test_boundary();
        int lat, nwr, nrd;
        bit err, oth;
        logic [23:0] rd, wa, wd;
        run_req(1'b0, 1'b0, 24'd125, 24'h000000, lat, err, rd, nwr, nrd, oth, wa, wd);
        n_checks++;
        if (lat != 3 || err !== 1'b0 || rd !== 24'h7D7E7F || nrd != 1) begin
            n_fail++;
            $display("FAIL addr125: got lat=%0d err=%0b rd=%h nrd=%0d, required 3 0 7d7e7f 1",
                     lat, err, rd, nrd);
        end
    endtask

    task automatic test_reset_mid_access();
        int lat, nwr, nrd;
        bit err, oth, saw_ack;
        logic [23:0] rd, wa, wd;
        saw_ack = 1'b0;
        @(posedge clk); #1;
        cpu_if.we = 1'b1; cpu_if.addr = 24'h000030; cpu_if.wdata = 24'h123456; cpu_if.req = 1'b1;
        @(posedge clk); #2;
        n_checks++;
        if (mem_if.mem_write !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_pre_access: got MemWrite=%0b, required 1", mem_if.mem_write);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (mem_if.mem_write !== 1'b0 || mem_if.address !== 24'h0 || cpu_if.rdata !== 24'h0) begin
            n_fail++;
            $display("FAIL rst_async: got MemWrite=%0b addr=%h rdata=%h, required 0 000000 000000",
                     mem_if.mem_write, mem_if.address, cpu_if.rdata);
        end
        cpu_if.req = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (cpu_if.ack) saw_ack = 1'b1;
        end
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (cpu_if.ack) saw_ack = 1'b1;
        end
        n_checks++;
        if (saw_ack || {tbmem[48], tbmem[49], tbmem[50]} !== 24'h303132) begin
            n_fail++;
            $display("FAIL rst_abort: got ack_seen=%0b bytes=%h, required 0 303132",
                     saw_ack, {tbmem[48], tbmem[49], tbmem[50]});
        end
        run_req(1'b0, 1'b0, 24'h000010, 24'h000000, lat, err, rd, nwr, nrd, oth, wa, wd);
        n_checks++;
        if (lat != 3 || err !== 1'b0 || rd !== 24'hA1B2C3) begin
            n_fail++;
            $display("FAIL rst_fresh_req: got lat=%0d err=%0b rd=%h, required 3 0 a1b2c3", lat, err, rd);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < MEM_BYTES; i++) tbmem[i] = 8'(i);
        cpu_if.req = 1'b0; cpu_if.we = 1'b0; cpu_if.addr = '0; cpu_if.wdata = '0;
        dbg_if.req = 1'b0; dbg_if.we = 1'b0; dbg_if.addr = '0; dbg_if.wdata = '0;
        rst_n = 1'b0;

        test_reset();
        test_simultaneous();
        test_back_to_back();
        test_store_load();
        test_range_error();
        test_boundary();
        test_reset_mid_access();

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_dmem_port_arbiter
`default_nettype wire
